io_input_port: RTL

IO_INPUT_PORT -- requirements
Module: io_input_port

---
 rtl/io_input_port.sv | 122 ++++++++++++
 1 files changed

// File: rtl/io_input_port.sv
// Pushbutton-latched 16-bit input port; debounce enabled by IO_INPUT_PORT_DEBOUNCE_EN.
// Latency: capture 3 + DB_CYCLES clk after press (3 without debounce); reads are combinational; no backpressure.
module io_input_port #(
    parameter logic [19:0] DB_CYCLES = 20'd500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pin,
    input  logic        pb,
    input  logic        cs,
    input  logic        addr,
    input  logic        rd_en,
    output logic [15:0] data_out,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HELD    = 2'd2
    } state_t;

    logic [15:0] pin_s1;
    logic [15:0] pin_s2;
    logic        pb_s1;
    logic        pb_s2;
    logic [1:0]  sync_vld;
    logic        pb_filt;
    logic        armed;
    state_t      state;
    logic [15:0] data;
    logic        ready;
    logic        overrun;
    logic        rd_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            pin_s1   <= 16'h0000;
            pin_s2   <= 16'h0000;
            pb_s1    <= 1'b0;
            pb_s2    <= 1'b0;
            sync_vld <= 2'b00;
        end else begin
            pin_s1   <= pin;
            pin_s2   <= pin_s1;
            pb_s1    <= pb;
            pb_s2    <= pb_s1;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

`ifdef IO_INPUT_PORT_DEBOUNCE_EN
    localparam logic [19:0] DB_LIM = (DB_CYCLES == 20'd0) ? 20'd1 : DB_CYCLES;
    logic [19:0] db_cnt;

    // Counter only runs while the synced level disagrees with the filtered one.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt  <= 20'd0;
            pb_filt <= 1'b0;
        end else if (pb_s2 == pb_filt) begin
            db_cnt  <= 20'd0;
        end else if (db_cnt >= DB_LIM - 20'd1) begin
            db_cnt  <= 20'd0;
            pb_filt <= pb_s2;
        end else begin
            db_cnt  <= db_cnt + 20'd1;
        end
    end
`else
    logic db_unused;
    assign db_unused = ^DB_CYCLES;
    assign pb_filt   = pb_s2;
`endif

    assign rd_clr = cs & ~addr & rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            data    <= 16'h0000;
            ready   <= 1'b0;
            overrun <= 1'b0;
            armed   <= 1'b0;
        end else begin
            // A button already held through reset must be seen released before it may capture.
            if (sync_vld[1] && !pb_filt && !pb_s2) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE:    if (armed && pb_filt) state <= CAPTURE;
                CAPTURE: state <= HELD;
                HELD:    if (!pb_filt) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (state == CAPTURE) begin
                data  <= pin_s2;
                ready <= 1'b1;
                if (ready) begin
                    overrun <= 1'b1;
                end
            end else if (rd_clr) begin
                ready   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

    assign irq = ready;

    always_comb begin
        data_out = 16'h0000;
        if (cs) begin
            if (addr) begin
                data_out = {13'b0, overrun, state == HELD, ready};
            end else begin
                data_out = data;
            end
        end
    end

endmodule
